// File: rtl/cv32e40p_aligner_tmr_pkg.sv
// Shared types for the TMR instruction aligner.
//   aligner_state_e : aligner FSM state, fixed 2-bit encoding
//   RH_RESET        : reset value of the residual halfword register
//   is_rvc()        : 1 when a 2-bit opcode field marks a compressed instruction
package cv32e40p_pkg2_ft;

    typedef enum logic [1:0] {
        ALIGNED           = 2'b00,
        MISALIGNED32      = 2'b01,
        MISALIGNED16      = 2'b10,
        BRANCH_MISALIGNED = 2'b11
    } aligner_state_e;

    localparam logic [15:0] RH_RESET = 16'h0000;

    function automatic logic is_rvc(input logic [1:0] op);
        return (op != 2'b11);
    endfunction

endpackage

// File: rtl/cv32e40p_aligner_tmr_if.sv
// Fetch / issue / redirect bundle of the aligner.
//   master : fetch side + downstream + branch source (drives *_i)
//   slave  : the aligner (drives *_o)
interface cv32e40p_aligner_tmr_if;

    logic        fetch_valid_i;
    logic [31:0] fetch_rdata_i;
    logic        aligner_ready_o;
    logic        if_valid_i;
    logic [31:0] instr_aligned_o;
    logic        instr_valid_o;
    logic        branch_i;
    logic [31:0] branch_addr_i;
    logic [31:0] pc_o;

    modport master (
        output fetch_valid_i, fetch_rdata_i, if_valid_i, branch_i, branch_addr_i,
        input  aligner_ready_o, instr_aligned_o, instr_valid_o, pc_o
    );

    modport slave (
        input  fetch_valid_i, fetch_rdata_i, if_valid_i, branch_i, branch_addr_i,
        output aligner_ready_o, instr_aligned_o, instr_valid_o, pc_o
    );

endinterface

// File: rtl/cv32e40p_tmr_reg.sv
// Triplicated register with bitwise 2-of-3 voter and disagreement flag.
// All copies reload from i_d every cycle, so the caller feeds back the voted
// value to scrub a single upset within one cycle.
//   clk, rst_n  : clock, asynchronous active-low reset
//   i_d         : next value (loaded into every copy)
//   o_q         : voted value
//   o_mismatch  : some bit differs between copies (always 0 when TMR=0)
module cv32e40p_tmr_reg #(
    parameter int           W         = 32,
    parameter logic [W-1:0] RESET_VAL = '0,
    parameter bit           TMR       = 1'b1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q,
    output logic         o_mismatch
);

    logic [W-1:0] r_q0;
    logic [W-1:0] r_q1;
    logic [W-1:0] r_q2;

    generate
        if (TMR) begin : g_tmr
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_q0 <= RESET_VAL;
                    r_q1 <= RESET_VAL;
                    r_q2 <= RESET_VAL;
                end else begin
                    r_q0 <= i_d;
                    r_q1 <= i_d;
                    r_q2 <= i_d;
                end
            end
            assign o_mismatch = |((r_q0 ^ r_q1) | (r_q0 ^ r_q2));
        end else begin : g_single
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) r_q0 <= RESET_VAL;
                else        r_q0 <= i_d;
            end
            // Mirror the single copy so the shared voter degenerates to a wire.
            assign r_q1       = r_q0;
            assign r_q2       = r_q0;
            assign o_mismatch = 1'b0;
        end
    endgenerate

    assign o_q = (r_q0 & r_q1) | (r_q0 & r_q2) | (r_q1 & r_q2);

endmodule

// File: rtl/cv32e40p_aligner_tmr.sv
// Instruction aligner between prefetch buffer and compressed decoder.
// Turns word-aligned fetch data into one aligned instruction per advance,
// handling RVC, word-straddling 32-bit instructions and halfword branch
// targets. State, PC and residual halfword live in voted TMR registers.
//   clk, rst_n       : clock, asynchronous active-low reset
//   bus (slave)      : fetch_valid_i/fetch_rdata_i/aligner_ready_o,
//                      if_valid_i/instr_aligned_o/instr_valid_o/pc_o,
//                      branch_i/branch_addr_i
//   err_detected_o   : copies disagree or voted state illegal this cycle
//   err_corrected_o  : copy disagreement masked by the vote this cycle
module cv32e40p_aligner_tmr
    import cv32e40p_pkg2_ft::*;
#(
    parameter logic [31:0] PC_RESET = 32'h0000_0000,
    parameter bit          EN_TMR   = 1'b1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    cv32e40p_aligner_tmr_if.slave        bus,
    output logic                         err_detected_o,
    output logic                         err_corrected_o
);

    logic [1:0]     w_state_raw;
    aligner_state_e w_state_q;
    aligner_state_e w_state_n;
    logic [31:0]    w_pc_q;
    logic [31:0]    w_pc_n;
    logic [15:0]    w_rh_q;
    logic [15:0]    w_rh_n;
    logic           w_mis_state;
    logic           w_mis_pc;
    logic           w_mis_rh;
    logic           w_illegal;
    logic           w_ready;
    logic           w_valid;
    logic [31:0]    w_instr;
    logic [31:0]    w_rdata;

    cv32e40p_tmr_reg #(.W(2), .RESET_VAL(ALIGNED), .TMR(EN_TMR)) u_state (
        .clk(clk), .rst_n(rst_n), .i_d(w_state_n), .o_q(w_state_raw), .o_mismatch(w_mis_state)
    );

    cv32e40p_tmr_reg #(.W(32), .RESET_VAL(PC_RESET), .TMR(EN_TMR)) u_pc (
        .clk(clk), .rst_n(rst_n), .i_d(w_pc_n), .o_q(w_pc_q), .o_mismatch(w_mis_pc)
    );

    cv32e40p_tmr_reg #(.W(16), .RESET_VAL(RH_RESET), .TMR(EN_TMR)) u_rh (
        .clk(clk), .rst_n(rst_n), .i_d(w_rh_n), .o_q(w_rh_q), .o_mismatch(w_mis_rh)
    );

    assign w_rdata = bus.fetch_rdata_i;

    // An encoding outside the enum falls back to ALIGNED and is flagged.
    always_comb begin
        w_illegal = 1'b0;
        case (w_state_raw)
            2'b00:   w_state_q = ALIGNED;
            2'b01:   w_state_q = MISALIGNED32;
            2'b10:   w_state_q = MISALIGNED16;
            2'b11:   w_state_q = BRANCH_MISALIGNED;
            default: begin
                w_state_q = ALIGNED;
                w_illegal = 1'b1;
            end
        endcase
    end

    always_comb begin
        w_ready   = 1'b1;
        w_valid   = 1'b0;
        w_instr   = w_rdata;
        w_state_n = w_state_q;
        w_pc_n    = w_pc_q;
        w_rh_n    = w_rh_q;

        case (w_state_q)
            ALIGNED: begin
                w_valid = bus.fetch_valid_i;
                if (w_valid && bus.if_valid_i) begin
                    if (!is_rvc(w_rdata[1:0])) begin
                        w_pc_n = w_pc_q + 32'd4;
                    end else begin
                        w_pc_n    = w_pc_q + 32'd2;
                        w_rh_n    = w_rdata[31:16];
                        w_state_n = is_rvc(w_rdata[17:16]) ? MISALIGNED16 : MISALIGNED32;
                    end
                end
            end
            MISALIGNED32: begin
                w_valid = bus.fetch_valid_i;
                w_instr = {w_rdata[15:0], w_rh_q};
                if (w_valid && bus.if_valid_i) begin
                    w_pc_n    = w_pc_q + 32'd4;
                    w_rh_n    = w_rdata[31:16];
                    w_state_n = is_rvc(w_rdata[17:16]) ? MISALIGNED16 : MISALIGNED32;
                end
            end
            MISALIGNED16: begin
                // Residual RVC is already buffered; hold the fetch word back.
                w_ready = 1'b0;
                w_valid = 1'b1;
                w_instr = {16'h0000, w_rh_q};
                if (bus.if_valid_i) begin
                    w_pc_n    = w_pc_q + 32'd2;
                    w_state_n = ALIGNED;
                end
            end
            BRANCH_MISALIGNED: begin
                w_instr = {16'h0000, w_rdata[31:16]};
                if (!is_rvc(w_rdata[17:16])) begin
                    // Upper half starts a 32-bit instruction: buffer it, issue nothing.
                    if (bus.fetch_valid_i) begin
                        w_rh_n    = w_rdata[31:16];
                        w_state_n = MISALIGNED32;
                    end
                end else begin
                    w_valid = bus.fetch_valid_i;
                    if (w_valid && bus.if_valid_i) begin
                        w_pc_n    = w_pc_q + 32'd2;
                        w_state_n = ALIGNED;
                    end
                end
            end
            default: ;
        endcase

        // Redirect wins over everything; the current fetch word is dropped.
        if (bus.branch_i) begin
            w_valid   = 1'b0;
            w_ready   = 1'b1;
            w_pc_n    = {bus.branch_addr_i[31:1], 1'b0};
            w_rh_n    = w_rh_q;
            w_state_n = bus.branch_addr_i[1] ? BRANCH_MISALIGNED : ALIGNED;
        end
    end

    assign bus.aligner_ready_o = w_ready;
    assign bus.instr_valid_o   = w_valid;
    assign bus.instr_aligned_o = w_instr;
    assign bus.pc_o            = w_pc_q;

    assign err_corrected_o = EN_TMR ? (w_mis_state | w_mis_pc | w_mis_rh) : 1'b0;
    assign err_detected_o  = EN_TMR ? (w_mis_state | w_mis_pc | w_mis_rh | w_illegal) : 1'b0;

endmodule

// File: tb/tb_cv32e40p_aligner_tmr.sv
// Self-checking bench for cv32e40p_aligner_tmr: halfword-stream reference
// model compared every cycle, plus hand-computed directed expectations.
module tb_cv32e40p_aligner_tmr;

    localparam logic [31:0] PC_RST = 32'h0000_0000;

    logic clk;
    logic rst_n;
    logic err_detected;
    logic err_corrected;

    cv32e40p_aligner_tmr_if bus ();

    cv32e40p_aligner_tmr #(.PC_RESET(PC_RST), .EN_TMR(1'b1)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .bus             (bus),
        .err_detected_o  (err_detected),
        .err_corrected_o (err_corrected)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_on   = 1'b0;
    bit err_dc   = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: pending halfword (m_hv/m_h), pending skip of the low
    // half after a halfword branch target, and the PC of the next instruction.
    logic [31:0] m_pc;
    logic [15:0] m_h;
    bit          m_hv;
    bit          m_skip;
    logic        e_valid;
    logic        e_ready;
    logic [31:0] e_instr;

    always_comb begin
        e_valid = 1'b0;
        e_ready = 1'b1;
        e_instr = 32'h0;
        if (bus.branch_i) begin
            e_valid = 1'b0;
        end else if (m_hv && m_h[1:0] != 2'b11) begin
            e_valid = 1'b1;
            e_ready = 1'b0;
            e_instr = {16'h0, m_h};
        end else if (m_hv) begin
            e_valid = bus.fetch_valid_i;
            e_instr = {bus.fetch_rdata_i[15:0], m_h};
        end else if (m_skip) begin
            if (bus.fetch_rdata_i[17:16] != 2'b11) begin
                e_valid = bus.fetch_valid_i;
                e_instr = {16'h0, bus.fetch_rdata_i[31:16]};
            end
        end else begin
            e_valid = bus.fetch_valid_i;
            e_instr = bus.fetch_rdata_i;
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pc   <= PC_RST;
            m_h    <= 16'h0;
            m_hv   <= 1'b0;
            m_skip <= 1'b0;
        end else if (bus.branch_i) begin
            m_pc   <= bus.branch_addr_i & ~32'h1;
            m_hv   <= 1'b0;
            m_skip <= bus.branch_addr_i[1];
        end else if (m_hv && m_h[1:0] != 2'b11) begin
            if (bus.if_valid_i && e_valid) begin
                m_pc <= m_pc + 32'd2;
                m_hv <= 1'b0;
            end
        end else if (m_hv) begin
            if (bus.if_valid_i && e_valid) begin
                m_pc <= m_pc + 32'd4;
                m_h  <= bus.fetch_rdata_i[31:16];
            end
        end else if (m_skip) begin
            if (bus.fetch_valid_i && bus.fetch_rdata_i[17:16] == 2'b11) begin
                m_h    <= bus.fetch_rdata_i[31:16];
                m_hv   <= 1'b1;
                m_skip <= 1'b0;
            end else if (bus.if_valid_i && e_valid) begin
                m_pc   <= m_pc + 32'd2;
                m_skip <= 1'b0;
            end
        end else if (bus.if_valid_i && e_valid) begin
            if (bus.fetch_rdata_i[1:0] == 2'b11) begin
                m_pc <= m_pc + 32'd4;
            end else begin
                m_pc <= m_pc + 32'd2;
                m_h  <= bus.fetch_rdata_i[31:16];
                m_hv <= 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_on && rst_n) begin
            chk("model_valid", {31'h0, bus.instr_valid_o}, {31'h0, e_valid});
            chk("model_ready", {31'h0, bus.aligner_ready_o}, {31'h0, e_ready});
            chk("model_pc", bus.pc_o, m_pc);
            if (e_valid) chk("model_instr", bus.instr_aligned_o, e_instr);
            if (!err_dc) begin
                chk("model_err_det", {31'h0, err_detected}, 32'h0);
                chk("model_err_cor", {31'h0, err_corrected}, 32'h0);
            end
        end
    end

    task automatic set_in(input logic fv, input logic [31:0] w, input logic ifv,
                          input logic br, input logic [31:0] ba);
        @(posedge clk);
        #1;
        bus.fetch_valid_i = fv;
        bus.fetch_rdata_i = w;
        bus.if_valid_i    = ifv;
        bus.branch_i      = br;
        bus.branch_addr_i = ba;
        #1;
    endtask

    task automatic do_reset();
        bus.fetch_valid_i = 1'b0;
        bus.fetch_rdata_i = 32'h0;
        bus.if_valid_i    = 1'b0;
        bus.branch_i      = 1'b0;
        bus.branch_addr_i = 32'h0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        chk("rst_pc", bus.pc_o, PC_RST);
        chk("rst_ready", {31'h0, bus.aligner_ready_o}, 32'h1);
        chk("rst_valid", {31'h0, bus.instr_valid_o}, 32'h0);
        chk("rst_rh", {16'h0, dut.w_rh_q}, 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;
        do_reset();
        chk_on = 1'b1;

        // 32-bit instruction in ALIGNED
        set_in(1, 32'h0041_0113, 1, 0, 0);
        chk("a32_valid", {31'h0, bus.instr_valid_o}, 32'h1);
        chk("a32_instr", bus.instr_aligned_o, 32'h0041_0113);
        chk("a32_pc", bus.pc_o, 32'h0);
        set_in(0, 32'h0, 0, 0, 0);
        chk("a32_pc_next", bus.pc_o, 32'h4);

        // RVC then 16-bit upper half
        do_reset();
        set_in(1, 32'h0001_4501, 1, 0, 0);
        chk("c16_instr_lo", {16'h0, bus.instr_aligned_o[15:0]}, 32'h4501);
        chk("c16_pc", bus.pc_o, 32'h0);
        set_in(0, 32'h0, 1, 0, 0);
        chk("m16_instr", bus.instr_aligned_o, 32'h0000_0001);
        chk("m16_ready", {31'h0, bus.aligner_ready_o}, 32'h0);
        chk("m16_valid", {31'h0, bus.instr_valid_o}, 32'h1);
        chk("m16_pc", bus.pc_o, 32'h2);
        set_in(0, 32'h0, 0, 0, 0);
        chk("m16_pc_next", bus.pc_o, 32'h4);
        chk("m16_back_aligned", {31'h0, bus.instr_valid_o}, 32'h0);

        // Straddling 32-bit instruction
        do_reset();
        set_in(1, 32'h0113_4501, 1, 0, 0);
        chk("str_first", {16'h0, bus.instr_aligned_o[15:0]}, 32'h4501);
        set_in(1, 32'h0000_0041, 1, 0, 0);
        chk("str_instr", bus.instr_aligned_o, 32'h0041_0113);
        chk("str_pc", bus.pc_o, 32'h2);
        set_in(0, 32'h0, 1, 0, 0);
        chk("str_pc_next", bus.pc_o, 32'h6);
        chk("str_tail_rvc", bus.instr_aligned_o, 32'h0);
        set_in(0, 32'h0, 0, 0, 0);
        chk("str_tail_pc", bus.pc_o, 32'h8);

        // Branch to halfword target, RVC at upper half
        do_reset();
        set_in(1, 32'h0041_0113, 1, 1, 32'h0000_0102);
        chk("br_valid", {31'h0, bus.instr_valid_o}, 32'h0);
        chk("br_ready", {31'h0, bus.aligner_ready_o}, 32'h1);
        set_in(1, 32'h4505_1234, 1, 0, 0);
        chk("br_pc", bus.pc_o, 32'h0000_0102);
        chk("br_instr", bus.instr_aligned_o, 32'h0000_4505);
        chk("br_ivalid", {31'h0, bus.instr_valid_o}, 32'h1);
        set_in(0, 32'h0, 0, 0, 0);
        chk("br_pc_next", bus.pc_o, 32'h0000_0104);

        // Branch to halfword target, 32-bit instruction at upper half
        set_in(0, 32'h0, 0, 1, 32'h0000_0207);
        set_in(1, 32'h0113_ABCD, 1, 0, 0);
        chk("brm32_valid", {31'h0, bus.instr_valid_o}, 32'h0);
        chk("brm32_pc", bus.pc_o, 32'h0000_0206);
        set_in(1, 32'h0000_0041, 1, 0, 0);
        chk("brm32_instr", bus.instr_aligned_o, 32'h0041_0113);
        set_in(0, 32'h0, 0, 0, 0);
        chk("brm32_pc_next", bus.pc_o, 32'h0000_020A);

        // PC wrap
        set_in(0, 32'h0, 0, 1, 32'hFFFF_FFFC);
        set_in(1, 32'h0041_0113, 1, 0, 0);
        chk("wrap_pc", bus.pc_o, 32'hFFFF_FFFC);
        set_in(0, 32'h0, 0, 0, 0);
        chk("wrap_pc_next", bus.pc_o, 32'h0);

        // Single-copy upset of pc bit 3
        set_in(0, 32'h0, 0, 0, 32'h0000_0010);
        set_in(0, 32'h0, 0, 1, 32'h0000_0010);
        set_in(0, 32'h0, 0, 0, 0);
        err_dc = 1'b1;
        force dut.u_pc.r_q1 = 32'h0000_0018;
        #1;
        chk("seu_det", {31'h0, err_detected}, 32'h1);
        chk("seu_cor", {31'h0, err_corrected}, 32'h1);
        chk("seu_pc", bus.pc_o, 32'h0000_0010);
        release dut.u_pc.r_q1;
        @(posedge clk);
        #1;
        err_dc = 1'b0;
        chk("seu_clear", {31'h0, err_detected}, 32'h0);
        chk("seu_pc_after", bus.pc_o, 32'h0000_0010);

        // Asynchronous reset while in MISALIGNED32
        do_reset();
        set_in(1, 32'h0113_4501, 1, 0, 0);
        set_in(1, 32'h0000_0041, 0, 0, 0);
        chk("arst_pre_instr", bus.instr_aligned_o, 32'h0041_0113);
        chk("arst_pre_pc", bus.pc_o, 32'h2);
        rst_n = 1'b0;
        #1;
        chk("arst_pc", bus.pc_o, PC_RST);
        chk("arst_instr", bus.instr_aligned_o, 32'h0000_0041);
        chk("arst_rh", {16'h0, dut.w_rh_q}, 32'h0);
        chk("arst_ready", {31'h0, bus.aligner_ready_o}, 32'h1);
        do_reset();
        set_in(0, 32'h0, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
